// File: rtl/switch_debouncer.sv
// Multi-channel slide-switch debouncer: per-bit two-flop synchronizer, saturating
// agreement counter and stable register, plus registered edge/change pulses.
module switch_debouncer #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din_raw,
  output logic [WIDTH-1:0] dout,
  output logic             any_on,
  output logic             changed,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // A one-cycle filter would be no filter at all, so refuse to build it.
  if (DEBOUNCE_CYCLES < 2) begin : gen_illegal_debounce_cycles
    $fatal(1, "switch_debouncer: DEBOUNCE_CYCLES must be at least 2");
  end

  logic [WIDTH-1:0] s1_q, s1_d;
  logic [WIDTH-1:0] s2_q, s2_d;
  logic [WIDTH-1:0] stb_q, stb_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic             changed_q, changed_d;
  logic             any_on_q, any_on_d;

  // Next-state: synchronizer shift, per-channel count/accept, and pulses derived
  // from the stable register so they line up with the new dout value.
  always_comb begin
    s1_d  = din_raw;
    s2_d  = s1_q;
    stb_d = stb_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = CNT_ZERO;
      if (s2_q[i] == stb_q[i]) begin
        cnt_d[i] = CNT_ZERO;
      end else if (cnt_q[i] >= CNT_MAX) begin
        stb_d[i] = s2_q[i];
        cnt_d[i] = CNT_ZERO;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
    rise_d    = stb_d & ~stb_q;
    fall_d    = ~stb_d & stb_q;
    changed_d = |(stb_d ^ stb_q);
    any_on_d  = |stb_d;
  end

  // State registers; reset clears everything, including any partial count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q      <= {WIDTH{1'b0}};
      s2_q      <= {WIDTH{1'b0}};
      stb_q     <= {WIDTH{1'b0}};
      rise_q    <= {WIDTH{1'b0}};
      fall_q    <= {WIDTH{1'b0}};
      changed_q <= 1'b0;
      any_on_q  <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= CNT_ZERO;
      end
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      stb_q     <= stb_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      changed_q <= changed_d;
      any_on_q  <= any_on_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign dout    = stb_q;
  assign any_on  = any_on_q;
  assign changed = changed_q;
  assign rise    = rise_q;
  assign fall    = fall_q;

endmodule

// File: doc/switch_debouncer.md
SWITCH_DEBOUNCER -- requirements
Module: switch_debouncer

Interface
REQ-001 Parameter WIDTH, default 8: number of independent switch channels.
REQ-002 Parameter DEBOUNCE_CYCLES, default 1000000: consecutive clk cycles of disagreement required to accept a new level (10 ms at 100 MHz).
REQ-003 Port clk, input, 1: single system clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-high reset.
REQ-005 Port din_raw, input, WIDTH: raw, asynchronous, bouncing slide-switch levels.
REQ-006 Port dout, output, WIDTH: debounced, clk-synchronous switch levels; feeds the downstream priority encoder's din.
REQ-007 Port any_on, output, 1: high when any dout bit is 1; marks the encoder output as valid, not don't-care.
REQ-008 Port changed, output, 1: one-cycle pulse when dout takes a new value.
REQ-009 Port rise, output, WIDTH: per-bit one-cycle pulse when that dout bit goes 0->1.
REQ-010 Port fall, output, WIDTH: per-bit one-cycle pulse when that dout bit goes 1->0.

Function
REQ-011 Each din_raw bit passes through a two-flop synchronizer (s1, s2) before any other use; no combinational path from din_raw to any output.
REQ-012 Each bit has its own counter cnt[i], width ceil(log2(DEBOUNCE_CYCLES)), and stable register stb[i]; dout = stb.
REQ-013 At each edge where s2[i] == stb[i], cnt[i] <= 0 and stb[i] holds; any single-cycle agreement restarts the count.
REQ-014 At each edge where s2[i] != stb[i] and cnt[i] < DEBOUNCE_CYCLES-1, cnt[i] increments by 1.
REQ-015 At each edge where s2[i] != stb[i] and cnt[i] == DEBOUNCE_CYCLES-1, stb[i] <= s2[i] and cnt[i] <= 0.
REQ-016 Counter never exceeds DEBOUNCE_CYCLES-1; no wrap-around.
REQ-017 Latency: a din_raw level held steady from before edge k (first edge that samples it into s1) appears on dout after edge k+1+DEBOUNCE_CYCLES.
REQ-018 Channels are fully independent; simultaneous updates on several bits at the same edge are all accepted at that edge.
REQ-019 rise, fall and changed are registered and asserted in the same cycle that dout shows the new value, for exactly one cycle.
REQ-020 changed = OR of the rise and fall bits for that cycle; rise[i] and fall[i] never assert together.
REQ-021 any_on is registered alongside stb: any_on = OR of the stb bits after the edge.
REQ-022 Bounce shorter than DEBOUNCE_CYCLES consecutive cycles produces no dout change and no pulses.
REQ-023 DEBOUNCE_CYCLES < 2 is illegal; elaboration fails.

Reset
REQ-024 While rst is high: s1, s2, cnt, stb, dout, any_on, changed, rise and fall are all 0, independent of clk.
REQ-025 Reset asserted mid-count discards the partial count; after release, counting restarts from 0 against stb = 0.
REQ-026 Deassertion needs no ordering with din_raw; synchronizers absorb the first sampled level.

Verification (DEBOUNCE_CYCLES = 4 for simulation)
REQ-027 Reset, then din_raw = 8'h00 for 20 cycles -> dout = 00, any_on = 0; changed, rise and fall never assert.
REQ-028 din_raw 00->8'h81 before edge k and held -> dout = 81 after edge k+5; rise = 81, changed = 1 and any_on = 1 for one cycle; next cycle rise = 00, changed = 0.
REQ-029 Bit 3 toggles 1,0,1,0 for 3 cycles each from dout = 00 -> dout stays 00, no pulses; then held at 1 -> dout = 08 after 4 disagreeing edges.
REQ-030 From dout = FF, din_raw -> 00 held -> fall = FF for one cycle, dout = 00, any_on = 0.
REQ-031 din_raw = 8'h10 held, rst pulsed high after 2 counting edges -> outputs 0 immediately; after release, dout = 10 exactly 5 edges after the first post-reset edge.
REQ-032 Bit 0 rises and bit 7 falls at the same edge -> rise = 01, fall = 80, changed = 1 in that single cycle.
